alu_operand_fetch: RTL and testbench
====================================

// Module: alu_operand_fetch
// PURPOSE
//   Operand-fetch stage directly upstream of the ALU. Decodes an instruction word,
//   reads two source registers from an internal register file and presents opcode/op1/op2
//   to the ALU through a 1-deep registered valid/ready output. ALU results return on the
//   write-back port. A per-register pending scoreboard stalls issue on RAW/WAW hazards.
// PARAMETERS
//   WIDTH   32  data width of registers, op1, op2, wb_data
//   op      2   opcode width (matches ALU opcode; 0 add, 1 sub, 2 mult, 3 nand)
//   ADDR_W  3   register address width; 2**ADDR_W registers, R0 hardwired to zero
//   INSTR_W localparam = op + 3*ADDR_W
// PORTS
//   clk       in   1        rising-edge clock
//   rst       in   1        synchronous active-high reset
//   in_valid  in   1        in_instr valid
//   in_ready  out  1        stage accepts in_instr this cycle
//   in_instr  in   INSTR_W  {opcode, rd, rs1, rs2}, opcode in MSBs, rs2 in LSBs
//   out_valid out  1        opcode/op1/op2/out_rd valid toward ALU
//   out_ready in   1        downstream consumes output this cycle
//   opcode    out  op       registered opcode to ALU
//   op1       out  WIDTH    registered rs1 value
//   op2       out  WIDTH    registered rs2 value
//   out_rd    out  ADDR_W   registered destination, carried to write-back
//   wb_en     in   1        write-back strobe
//   wb_addr   in   ADDR_W   write-back register
//   wb_data   in   WIDTH    write-back data (ALU result)
//   busy      out  1        OR of all pending bits
// BEHAVIOUR
//   - Reset: out_valid=0, opcode/op1/op2/out_rd=0, all registers=0, pending=0, busy=0.
//     Reset mid-operation drops the held output and clears the scoreboard.
//   - Read: R0 reads 0. For rs!=0: if wb_en && wb_addr==rs, value = wb_data (bypass),
//     else regs[rs].
//   - wb_rel(r) = wb_en && wb_addr==r. hazard = (pending[rs1] && !wb_rel(rs1))
//     || (pending[rs2] && !wb_rel(rs2)) || (pending[rd] && !wb_rel(rd)). pending[0] is always 0.
//   - in_ready = (!out_valid || out_ready) && !hazard. Combinational on in_instr,
//     out_valid, out_ready and wb_*; never depends on in_valid.
//   - accept = in_valid && in_ready. On accept: outputs load decoded fields and read values
//     at the next edge and out_valid<=1. One-cycle latency, full throughput.
//   - No accept && out_ready: out_valid<=0. While out_valid && !out_ready, outputs hold.
//   - Write-back: wb_en && wb_addr!=0 writes regs[wb_addr] and clears pending[wb_addr].
//     A write to a non-pending register is legal. Writes to R0 are ignored.
//   - Accept with rd!=0 sets pending[rd]. Same-cycle set and clear on one register: set wins.
//   - busy is registered: |pending after the edge.
// TESTING
//   1 rst=1 for 2 cycles -> out_valid=0, busy=0, in_ready=1, any later read of R5 = 0.
//   2 wb R1=5, R2=7, then issue {op=0,rd=3,rs1=1,rs2=2} -> next cycle out_valid=1, op1=5,
//     op2=7, opcode=0, out_rd=3, busy=1.
//   3 R3 pending, issue rs1=3 -> in_ready=0 and no accept. Same cycle wb_en addr=3
//     data=12 -> in_ready=1, next op1=12 (bypass), pending[3] cleared.
//   4 out_valid=1, out_ready=0 for 3 cycles, new instr offered -> in_ready=0, outputs stable.
//     out_ready=1 -> new instr accepted that cycle.
//   5 wb R0=0xFFFF_FFFF, issue rs1=0, rd=0 -> op1=0, busy stays 0.
//   6 accepted instr with rd=4 and out_valid=1, assert rst -> next cycle out_valid=0, busy=0.
//     Issue rs1=4 -> in_ready=1 immediately.

Source files
------------

// File: rtl/alu_operand_fetch.sv
// Operand-fetch stage ahead of the ALU: decodes {opcode, rd, rs1, rs2}, reads the
// register file with write-back bypass, and holds one registered operand bundle
// toward the ALU behind a valid/ready handshake. A per-register pending scoreboard
// blocks issue while any referenced register still awaits its write-back.
`timescale 1ns/1ps

module alu_operand_fetch #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned op     = 2,
  parameter int unsigned ADDR_W = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [op+3*ADDR_W-1:0]    in_instr,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [op-1:0]             opcode,
  output logic [WIDTH-1:0]          op1,
  output logic [WIDTH-1:0]          op2,
  output logic [ADDR_W-1:0]         out_rd,
  input  logic                      wb_en,
  input  logic [ADDR_W-1:0]         wb_addr,
  input  logic [WIDTH-1:0]          wb_data,
  output logic                      busy
);

  localparam int unsigned INSTR_W = op + 3*ADDR_W;
  localparam int unsigned NREG    = 2**ADDR_W;

  logic [op-1:0]     dec_opc;
  logic [ADDR_W-1:0] dec_rd;
  logic [ADDR_W-1:0] dec_rs1;
  logic [ADDR_W-1:0] dec_rs2;

  logic [WIDTH-1:0]  regs_q [NREG];
  logic [NREG-1:0]   pending_q, pending_d;
  logic              busy_q, busy_d;
  logic              out_valid_q, out_valid_d;
  logic [op-1:0]     opcode_q, opcode_d;
  logic [WIDTH-1:0]  op1_q, op1_d;
  logic [WIDTH-1:0]  op2_q, op2_d;
  logic [ADDR_W-1:0] out_rd_q, out_rd_d;

  logic [WIDTH-1:0]  rs1_val, rs2_val;
  logic              wb_nz;
  logic              rel_rs1, rel_rs2, rel_rd;
  logic              hazard;
  logic              accept;

  assign dec_rs2 = in_instr[ADDR_W-1:0];
  assign dec_rs1 = in_instr[2*ADDR_W-1:ADDR_W];
  assign dec_rd  = in_instr[3*ADDR_W-1:2*ADDR_W];
  assign dec_opc = in_instr[INSTR_W-1:3*ADDR_W];

  assign wb_nz   = wb_en && (wb_addr != '0);

  // Source reads: R0 is zero, a same-cycle write-back is forwarded.
  always_comb begin
    rs1_val = regs_q[dec_rs1];
    rs2_val = regs_q[dec_rs2];
    if (wb_en && (wb_addr == dec_rs1)) rs1_val = wb_data;
    if (wb_en && (wb_addr == dec_rs2)) rs2_val = wb_data;
    if (dec_rs1 == '0) rs1_val = '0;
    if (dec_rs2 == '0) rs2_val = '0;
  end

  // Hazard: a referenced register is pending and not being released this cycle.
  always_comb begin
    rel_rs1  = wb_en && (wb_addr == dec_rs1);
    rel_rs2  = wb_en && (wb_addr == dec_rs2);
    rel_rd   = wb_en && (wb_addr == dec_rd);
    hazard   = (pending_q[dec_rs1] && !rel_rs1)
            || (pending_q[dec_rs2] && !rel_rs2)
            || (pending_q[dec_rd]  && !rel_rd);
    in_ready = (!out_valid_q || out_ready) && !hazard;
    accept   = in_valid && in_ready;
  end

  // Next state for the output slot and the scoreboard.
  always_comb begin
    out_valid_d = out_valid_q;
    opcode_d    = opcode_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    out_rd_d    = out_rd_q;
    pending_d   = pending_q;
    if (accept) begin
      out_valid_d = 1'b1;
      opcode_d    = dec_opc;
      op1_d       = rs1_val;
      op2_d       = rs2_val;
      out_rd_d    = dec_rd;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    // Clear first so a same-cycle set on the same register wins.
    if (wb_nz) pending_d[wb_addr] = 1'b0;
    if (accept && (dec_rd != '0)) pending_d[dec_rd] = 1'b1;
    pending_d[0] = 1'b0;
    busy_d       = |pending_d;
  end

  // Output slot and scoreboard registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      opcode_q    <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
      out_rd_q    <= '0;
      pending_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      opcode_q    <= opcode_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      out_rd_q    <= out_rd_d;
      pending_q   <= pending_d;
      busy_q      <= busy_d;
    end
  end

  // Register file; R0 is never written and stays zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NREG); i++) regs_q[i] <= '0;
    end else if (wb_nz) begin
      regs_q[wb_addr] <= wb_data;
    end
  end

  assign out_valid = out_valid_q;
  assign opcode    = opcode_q;
  assign op1       = op1_q;
  assign op2       = op2_q;
  assign out_rd    = out_rd_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_alu_operand_fetch.sv
// Bench for alu_operand_fetch: directed scenarios followed by random traffic, all
// checked against a register-array/pending-set reference model and an output queue.
`timescale 1ns/1ps

module tb_alu_operand_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [10:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  opcode;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [2:0]  out_rd;
  logic        wb_en;
  logic [2:0]  wb_addr;
  logic [31:0] wb_data;
  logic        busy;

  typedef struct packed {
    logic [1:0]  opc;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  rd;
  } item_t;

  item_t       exp_q[$];
  logic [31:0] m_regs [8];
  logic [7:0]  m_pend;
  int          errors = 0;
  int          checks = 0;
  bit          mon_en = 1'b0;

  alu_operand_fetch dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .opcode(opcode), .op1(op1), .op2(op2), .out_rd(out_rd),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [2:0] r, input logic we,
                                         input logic [2:0] wa, input logic [31:0] wd);
    if (r == 3'd0) return 32'd0;
    if (we && wa == r) return wd;
    return m_regs[r];
  endfunction

  function automatic bit m_blocked(input logic [2:0] r, input logic we, input logic [2:0] wa);
    return m_pend[r] && !(we && wa == r);
  endfunction

  // One clock cycle: entered and left at posedge+1.
  task automatic cycle(input bit r, input bit v, input logic [1:0] opc, input logic [2:0] rd,
                       input logic [2:0] rs1, input logic [2:0] rs2, input bit ordy,
                       input bit we, input logic [2:0] wa, input logic [31:0] wd);
    bit    exp_rdy;
    bit    acc;
    item_t it;
    rst = r; in_valid = v; in_instr = {opc, rd, rs1, rs2};
    out_ready = ordy; wb_en = we; wb_addr = wa; wb_data = wd;
    #1;
    exp_rdy = (exp_q.size() == 0 || ordy) &&
              !(m_blocked(rs1, we, wa) || m_blocked(rs2, we, wa) || m_blocked(rd, we, wa));
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    acc = v && exp_rdy && !r;
    it  = '{opc, m_read(rs1, we, wa, wd), m_read(rs2, we, wa, wd), rd};
    @(posedge clk); #1;
    if (r) begin
      for (int i = 0; i < 8; i++) m_regs[i] = 32'd0;
      m_pend = 8'd0;
      exp_q.delete();
    end else begin
      if (we && wa != 3'd0) begin
        m_regs[wa] = wd;
        m_pend[wa] = 1'b0;
      end
      if (acc) begin
        if (rd != 3'd0) m_pend[rd] = 1'b1;
        exp_q.push_back(it);
      end
    end
    check("busy", 32'(busy), 32'(|m_pend));
  endtask

  task automatic idle(input bit ordy);
    cycle(1'b0, 1'b0, 2'd0, 3'd0, 3'd0, 3'd0, ordy, 1'b0, 3'd0, 32'd0);
  endtask

  task automatic wb(input logic [2:0] wa, input logic [31:0] wd);
    cycle(1'b0, 1'b0, 2'd0, 3'd0, 3'd0, 3'd0, 1'b1, 1'b1, wa, wd);
  endtask

  // Monitor: compare the presented bundle with the queue head, pop on transfer.
  always @(negedge clk) begin
    if (mon_en) begin
      check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        check("opcode", 32'(opcode), 32'(exp_q[0].opc));
        check("op1", op1, exp_q[0].a);
        check("op2", op2, exp_q[0].b);
        check("out_rd", 32'(out_rd), 32'(exp_q[0].rd));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; out_ready = 1'b0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    m_pend = 8'd0;
    for (int i = 0; i < 8; i++) m_regs[i] = 32'd0;
    @(posedge clk); #1;

    // Reset for two cycles.
    cycle(1'b1, 1'b0, 2'd0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 32'd0);
    cycle(1'b1, 1'b0, 2'd0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 32'd0);
    mon_en = 1'b1;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset in_ready", 32'(in_ready), 32'd1);

    // R5 reads zero after reset; R0 write ignored and rd=0 leaves busy low.
    cycle(1'b0, 1'b1, 2'd1, 3'd0, 3'd5, 3'd5, 1'b1, 1'b1, 3'd0, 32'hFFFF_FFFF);
    cycle(1'b0, 1'b1, 2'd2, 3'd0, 3'd0, 3'd0, 1'b1, 1'b0, 3'd0, 32'd0);
    idle(1'b1);

    // Write R1/R2, issue add into R3.
    wb(3'd1, 32'd5);
    wb(3'd2, 32'd7);
    cycle(1'b0, 1'b1, 2'd0, 3'd3, 3'd1, 3'd2, 1'b0, 1'b0, 3'd0, 32'd0);
    check("directed op1", op1, 32'd5);
    check("directed op2", op2, 32'd7);

    // RAW on R3: stall, then release with bypass in the same cycle.
    cycle(1'b0, 1'b1, 2'd1, 3'd4, 3'd3, 3'd0, 1'b1, 1'b0, 3'd0, 32'd0);
    cycle(1'b0, 1'b1, 2'd1, 3'd4, 3'd3, 3'd0, 1'b1, 1'b1, 3'd3, 32'd12);
    check("bypass op1", op1, 32'd12);

    // Output held under back-pressure, then accepted when drained.
    for (int i = 0; i < 3; i++)
      cycle(1'b0, 1'b1, 2'd3, 3'd5, 3'd1, 3'd2, 1'b0, 1'b0, 3'd0, 32'd0);
    cycle(1'b0, 1'b1, 2'd3, 3'd5, 3'd1, 3'd2, 1'b1, 1'b0, 3'd0, 32'd0);
    idle(1'b1);

    // Reset with R4 pending and output held, then R4 is free again.
    wb(3'd4, 32'd1);
    wb(3'd5, 32'd2);
    cycle(1'b0, 1'b1, 2'd2, 3'd4, 3'd1, 3'd1, 1'b0, 1'b0, 3'd0, 32'd0);
    cycle(1'b1, 1'b0, 2'd0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 32'd0);
    check("post-reset busy", 32'(busy), 32'd0);
    cycle(1'b0, 1'b1, 2'd0, 3'd1, 3'd4, 3'd0, 1'b1, 1'b0, 3'd0, 32'd0);

    // Random traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      cycle(($urandom_range(0, 299) == 0),
            ($urandom_range(0, 9) < 7),
            2'($urandom), 3'($urandom), 3'($urandom), 3'($urandom),
            ($urandom_range(0, 9) < 7),
            ($urandom_range(0, 9) < 4),
            3'($urandom), $urandom);
    end
    for (int i = 0; i < 4; i++) idle(1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
